// File: rtl/systolic_array.sv
// 4x4 weight-stationary MAC array: activations flow right, partial sums
// flow down, bottom-row partial sums are the column results.
module systolic_array #(
  parameter int array_size = 4,
  parameter int data_size  = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [array_size*data_size-1:0]              datain,
  input  logic [array_size*array_size*data_size-1:0]   weightin,
  output logic [array_size*data_size-1:0]              macout
);

  localparam int N = array_size;
  localparam int W = data_size;

  logic [W-1:0] a_out [N][N];
  logic [W-1:0] p_out [N][N];

  genvar r, c;
  generate
    for (r = 0; r < N; r++) begin : g_row
      for (c = 0; c < N; c++) begin : g_col
        logic [W-1:0] a_in;
        logic [W-1:0] p_in;
        logic [W-1:0] w;
        logic [W-1:0] mac;
        logic [W-1:0] p_reg;

        if (c == 0) begin : g_a_edge
          assign a_in = datain[W*r +: W];
        end else begin : g_a_link
          assign a_in = a_out[r][c-1];
        end

        if (r == 0) begin : g_p_edge
          assign p_in = '0;
        end else begin : g_p_link
          assign p_in = p_out[r-1][c];
        end

        assign w   = weightin[W*(N*r+c) +: W];
        // product and sum both wrap modulo 2^W
        assign mac = p_in + a_in * w;

        always_ff @(posedge clk or negedge reset) begin
          if (!reset) p_reg <= '0;
          else        p_reg <= mac;
        end
        assign p_out[r][c] = p_reg;

        // last column's activation has no consumer, so it is not stored
        if (c < N-1) begin : g_a_reg
          logic [W-1:0] a_reg;
          always_ff @(posedge clk or negedge reset) begin
            if (!reset) a_reg <= '0;
            else        a_reg <= a_in;
          end
          assign a_out[r][c] = a_reg;
        end else begin : g_a_sink
          assign a_out[r][c] = '0;
        end
      end
    end

    for (c = 0; c < N; c++) begin : g_out
      assign macout[W*c +: W] = p_out[N-1][c];
    end
  endgenerate

endmodule

// File: tb/tb_systolic_array.sv
// Directed table-driven bench for systolic_array, plus hand-written
// sequences for asynchronous mid-stream reset and restart.
module tb_systolic_array;

  logic         clk;
  logic         reset;
  logic [31:0]  datain;
  logic [127:0] weightin;
  logic [31:0]  macout;

  systolic_array #(.array_size(4), .data_size(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .datain   (datain),
    .weightin (weightin),
    .macout   (macout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         rst;
    logic [127:0] w;
    logic [31:0]  d;
    logic [3:0]   mask;
    logic [31:0]  exp;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [127:0] W1 = 128'h100f0e0d0c0b0a090807060504030201;
  localparam logic [127:0] WF = {16{8'hFF}};

  task automatic add(input logic rst, input logic [127:0] w,
                     input logic [31:0] d, input logic [3:0] m,
                     input logic [31:0] e);
    vec_t v;
    v.rst = rst; v.w = w; v.d = d; v.mask = m; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [3:0] m, input logic [31:0] e);
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        n_checks++;
        if (macout[8*c +: 8] !== e[8*c +: 8]) begin
          n_fail++;
          $display("FAIL %s[%0d] col%0d: got %h expected %h",
                   nm, idx, c, macout[8*c +: 8], e[8*c +: 8]);
        end
      end
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    datain   = $urandom;
    weightin = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("reset_async", 0, 4'hF, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("reset_hold", i, 4'hF, 32'h0);
      datain   = $urandom;
      weightin = {$urandom, $urandom, $urandom, $urandom};
    end
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    datain   = '0;
    weightin = '0;

    // basic skewed product with held row-3 input
    add(1, W1, 32'h00000001, 4'b0000, 32'h0);
    add(0, W1, 32'h00000200, 4'b0000, 32'h0);
    add(0, W1, 32'h00030000, 4'b0000, 32'h0);
    add(0, W1, 32'h04000000, 4'b0001, 32'h0000005A);
    add(0, W1, 32'h04000000, 4'b0011, 32'h00006434);
    add(0, W1, 32'h04000000, 4'b0110, 32'h006E3800);
    add(0, W1, 32'h04000000, 4'b1000, 32'h78000000);
    // modulo-256 wrap-around
    add(1, WF, 32'h000000FF, 4'b0000, 32'h0);
    add(0, WF, 32'h0000FF00, 4'b0000, 32'h0);
    add(0, WF, 32'h00FF0000, 4'b0000, 32'h0);
    add(0, WF, 32'hFF000000, 4'b0001, 32'h00000004);
    add(0, WF, 32'h00000000, 4'b0011, 32'h00000400);
    add(0, WF, 32'h00000000, 4'b0100, 32'h00040000);
    add(0, WF, 32'h00000000, 4'b1000, 32'h04000000);
    // back-to-back vectors [1,2,3,4] then [1,1,1,1]
    add(1, W1, 32'h00000001, 4'b0000, 32'h0);
    add(0, W1, 32'h00000201, 4'b0000, 32'h0);
    add(0, W1, 32'h00030100, 4'b0000, 32'h0);
    add(0, W1, 32'h04010000, 4'b0001, 32'h0000005A);
    add(0, W1, 32'h01000000, 4'b0011, 32'h0000641C);
    add(0, W1, 32'h01000000, 4'b0110, 32'h006E2000);
    add(0, W1, 32'h01000000, 4'b1100, 32'h78240000);
    add(0, W1, 32'h01000000, 4'b1000, 32'h28000000);
    // zero weights
    add(1, 128'h0, 32'h12345678, 4'hF, 32'h0);
    add(0, 128'h0, 32'hDEADBEEF, 4'hF, 32'h0);
    add(0, 128'h0, 32'hFFFFFFFF, 4'hF, 32'h0);
    add(0, 128'h0, 32'h80808080, 4'hF, 32'h0);
    add(0, 128'h0, 32'h01020304, 4'hF, 32'h0);
    add(0, 128'h0, 32'hFFFFFFFF, 4'hF, 32'h0);
    add(0, 128'h0, 32'h7F7F7F7F, 4'hF, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      weightin = tbl[i].w;
      datain   = tbl[i].d;
      tick();
      chk("vec", i, tbl[i].mask, tbl[i].exp);
    end

    // asynchronous reset between edges while results are in flight
    do_reset();
    weightin = W1;
    datain = 32'h00000001; tick();
    datain = 32'h00000200; tick();
    datain = 32'h00030000; tick();
    datain = 32'h04000000; tick();
    chk("pre_async", 0, 4'b0001, 32'h0000005A);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_async", 0, 4'hF, 32'h0);
    tick();
    chk("mid_hold", 0, 4'hF, 32'h0);
    reset = 1'b1;
    datain = 32'h00000000; tick();
    chk("post_rel", 0, 4'hF, 32'h0);

    // restart from clean state
    datain = 32'h00000001; tick();
    datain = 32'h00000200; tick();
    datain = 32'h00030000; tick();
    datain = 32'h04000000; tick();
    chk("restart", 0, 4'b0001, 32'h0000005A);
    tick();
    chk("restart", 1, 4'b0011, 32'h00006434);
    tick();
    chk("restart", 2, 4'b0100, 32'h006E0000);
    tick();
    chk("restart", 3, 4'b1000, 32'h78000000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_array.md
Name: systolic_array

Overview:
- 4x4 weight-stationary systolic array of multiply-accumulate processing elements (PEs); the matrix-vector compute core of the CNN accelerator.
- Activations enter the left edge, one byte per row, and shift right one PE per clock.
- Partial sums enter the top as zero, accumulate downward one PE per clock, and exit the bottom row as one 8-bit result per column.
- The caller skews activations: row r is presented r cycles after row 0.

Parameters:
- array_size, 4, rows = columns of PEs; widths below assume 4. Only 4 needs to be supported.
- data_size, 8, bit width of activations, weights, products and partial sums.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears all PE registers.
- datain  input  32  row activations; row r = datain[8r+7:8r].
- weightin  input  128  stationary weights; PE(r,c) weight = weightin[8(4r+c)+7 : 8(4r+c)].
- macout  output  32  column results; column c = macout[8c+7:8c] = psum register of PE(3,c).

Behaviour:
- PE(r,c) holds two registers: a_reg (8 b) and p_reg (8 b).
- On each rising clk when reset is high:
  - a_reg <= a_in.
  - p_reg <= p_in + a_in * w(r,c).
- Operand sources:
  - a_in of PE(r,0) is the datain row r byte; a_in of PE(r,c>0) is a_reg of PE(r,c-1).
  - p_in of PE(0,c) is 0; p_in of PE(r>0,c) is p_reg of PE(r-1,c).
  - w(r,c) is taken combinationally from weightin. The caller holds weightin stable for the whole computation; no weight register or load strobe.
- Arithmetic: unsigned. The 8x8 product and the sum are both truncated to 8 bits (modulo 256). No saturation, no overflow flag.
- a_reg of the last column is discarded; there is no data output port.
- Reset:
  - reset low clears every a_reg and p_reg to 0 immediately, independent of clk. macout = 0 while reset is low.
  - Reset asserted mid-computation discards all in-flight data; computation restarts from zero after release.
- macout is purely registered (p_reg of the bottom row); no combinational input-to-output path.
- Latency and skew for a skewed input vector x:
  - Row r byte x_r is sampled at edge e_r = e_0 + r.
  - macout column c = sum over r of x_r * w(r,c) (mod 256), valid immediately after edge e_0 + 3 + c.
  - It holds for exactly one cycle, then changes as later data flows through.
- Inputs held after their slot keep being injected every cycle, e.g. row 3 held at 4 continues feeding 4. They affect later outputs only, not the designated result cycles.
- The array is fully pipelined: a new skewed vector may start every cycle. No handshake, no valid signal; callers track latency externally.

Test Plan:
- Reset: hold reset low with clk running and random datain/weightin -> macout = 0 every cycle. Assert reset low asynchronously between edges mid-stream -> macout = 0 immediately.
- Basic skewed matrix-vector product:
  - Stimulus: reset high at 20 ns, weightin = 128'h100f0e0d0c0b0a090807060504030201 (w(r,c) = 4r+c+1). datain = 32'h00000001, 00000200, 00030000, 04000000 on consecutive edges e0..e3, then held at 04000000.
  - Required: after e3, macout[7:0] = 8'h5A (90); after e4, macout[15:8] = 8'h64 (100); after e5, macout[23:16] = 8'h6E (110); after e6, macout[31:24] = 8'h78 (120).
- Held-input effect: same stimulus -> after e4, macout[7:0] = 8'h34 (52 = 4*13), because row 3 is still fed 4.
- Wrap-around: all weights 8'hFF, x = [8'hFF, 8'hFF, 8'hFF, 8'hFF] skewed -> each column result = 4*(255*255) mod 256 = 8'h04.
- Pipelining: issue two skewed vectors back-to-back one cycle apart, e.g. [1,2,3,4] then [1,1,1,1], with the weights above -> column c gives 90/100/110/120 at e3+c, then the column sums 28/32/36/40 at e4+c.
- Zero weights: weightin = 0, arbitrary datain -> macout remains 0 at all times.
